// File: rtl/btn_pkg.sv
// Shared button indices and centre-button FSM encoding for the pushbutton front end.
package btn_pkg;

  localparam int BTN_C   = 0;
  localparam int BTN_U   = 1;
  localparam int BTN_D   = 2;
  localparam int BTN_L   = 3;
  localparam int BTN_R   = 4;
  localparam int NUM_BTN = 5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESSED    = 2'd1,
    LONG_FIRED = 2'd2
  } c_state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce counter for one button.
// Emits the stable level and one-cycle rise/fall strobes, aligned with the level change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 360000
) (
  input  logic pixel_clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      // Any sample agreeing with the stable level restarts the count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_rise  <= r_sync2;
        r_fall  <= !r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton front end for game_fsm: debounce all five buttons, classify the centre
// press as short/long, and turn direction holds into move pulses with auto-repeat.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 360000,
  parameter int LONG_PRESS_CYCLES    = 25200000,
  parameter int REPEAT_DELAY_CYCLES  = 14400000,
  parameter int REPEAT_PERIOD_CYCLES = 5400000
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic               button_c_short,
  output logic               button_c_long,
  output logic               button_u,
  output logic               button_d,
  output logic               button_l,
  output logic               button_r,
  output logic [NUM_BTN-1:0] btn_level,
  output c_state_t           o_dbg_c_state
);

  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HC_FIRE = HW'(LONG_PRESS_CYCLES - 2);
  localparam int RW = $clog2(imax(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES));
  localparam logic [RW-1:0] RC_DELAY_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RC_PERIOD_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_fall;
  logic [3:0]         w_dir_pulse;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .pixel_clk(pixel_clk),
      .rst_n    (rst_n),
      .i_raw    (btn_raw[i]),
      .o_level  (w_level[i]),
      .o_rise   (w_rise[i]),
      .o_fall   (w_fall[i])
    );
  end

  c_state_t        r_c_state;
  c_state_t        w_c_state_nxt;
  logic [HW-1:0]   r_hc;
  logic [HW-1:0]   w_hc_nxt;
  logic            r_c_short;
  logic            r_c_long;
  logic            w_short_nxt;
  logic            w_long_nxt;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_c_state <= IDLE;
      r_hc      <= '0;
      r_c_short <= 1'b0;
      r_c_long  <= 1'b0;
    end else begin
      r_c_state <= w_c_state_nxt;
      r_hc      <= w_hc_nxt;
      r_c_short <= w_short_nxt;
      r_c_long  <= w_long_nxt;
    end
  end

  // hc is 0 on entry to PRESSED; long fires on the edge hc would reach LONG_PRESS_CYCLES-1.
  always_comb begin
    w_c_state_nxt = r_c_state;
    w_hc_nxt      = r_hc;
    w_short_nxt   = 1'b0;
    w_long_nxt    = 1'b0;
    case (r_c_state)
      IDLE: begin
        if (w_rise[BTN_C]) begin
          w_c_state_nxt = PRESSED;
          w_hc_nxt      = '0;
        end
      end
      PRESSED: begin
        w_hc_nxt = r_hc + HW'(1);
        if (w_fall[BTN_C]) begin
          w_short_nxt   = 1'b1;
          w_c_state_nxt = IDLE;
          w_hc_nxt      = '0;
        end else if (r_hc == HC_FIRE) begin
          w_long_nxt    = 1'b1;
          w_c_state_nxt = LONG_FIRED;
          w_hc_nxt      = '0;
        end
      end
      LONG_FIRED: begin
        if (w_fall[BTN_C]) w_c_state_nxt = IDLE;
      end
      default: begin
        w_c_state_nxt = IDLE;
        w_hc_nxt      = '0;
      end
    endcase
  end

  // Direction d drives button index d+1 (U, D, L, R); each repeats independently.
  for (genvar d = 0; d < 4; d++) begin : g_dir
    logic [RW-1:0] r_rc;
    logic          r_active;
    logic          r_period;
    logic          r_pulse;

    always_ff @(posedge pixel_clk) begin
      if (!rst_n) begin
        r_rc     <= '0;
        r_active <= 1'b0;
        r_period <= 1'b0;
        r_pulse  <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (w_fall[d+1]) begin
          r_rc     <= '0;
          r_active <= 1'b0;
          r_period <= 1'b0;
        end else if (w_rise[d+1]) begin
          r_pulse  <= 1'b1;
          r_rc     <= '0;
          r_active <= 1'b1;
          r_period <= 1'b0;
        end else if (r_active) begin
          if ((!r_period && r_rc == RC_DELAY_LAST) || (r_period && r_rc == RC_PERIOD_LAST)) begin
            r_pulse  <= 1'b1;
            r_rc     <= '0;
            r_period <= 1'b1;
          end else begin
            r_rc <= r_rc + RW'(1);
          end
        end
      end
    end

    assign w_dir_pulse[d] = r_pulse;
  end

  assign button_c_short = r_c_short;
  assign button_c_long  = r_c_long;
  assign button_u       = w_dir_pulse[BTN_U-1];
  assign button_d       = w_dir_pulse[BTN_D-1];
  assign button_l       = w_dir_pulse[BTN_L-1];
  assign button_r       = w_dir_pulse[BTN_R-1];
  assign btn_level      = w_level;
  assign o_dbg_c_state  = r_c_state;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Front-end conditioner for the five board pushbuttons, sitting directly upstream of the minesweeper game FSM in the game top.
- Synchronises and debounces the raw button inputs.
- Classifies the centre button as a short or long press.
- Converts direction buttons into single-cycle move pulses with hold-to-repeat.
- Outputs drive game_fsm's button_c_short, button_c_long, button_u/d/l/r, replacing the raw-level hookup and the tied-off long-press input.

Parameters:
DEBOUNCE_CYCLES, 360000, consecutive cycles a synchronised input must differ from the stable level before the stable level changes (10 ms at 36 MHz).
LONG_PRESS_CYCLES, 25200000, centre hold time that classifies a long press (700 ms).
REPEAT_DELAY_CYCLES, 14400000, hold time before the first direction auto-repeat (400 ms).
REPEAT_PERIOD_CYCLES, 5400000, interval between subsequent auto-repeats (150 ms).

Ports:
pixel_clk  input  1  pixel clock, 36 MHz
rst_n  input  1  synchronous reset, active-low
btn_raw  input  5  raw asynchronous buttons, index 0=C, 1=U, 2=D, 3=L, 4=R
button_c_short  output  1  one-cycle pulse: centre released before long threshold
button_c_long  output  1  one-cycle pulse: centre held LONG_PRESS_CYCLES
button_u  output  1  one-cycle move pulse, up
button_d  output  1  one-cycle move pulse, down
button_l  output  1  one-cycle move pulse, left
button_r  output  1  one-cycle move pulse, right
btn_level  output  5  debounced stable levels, same indexing as btn_raw

Behaviour:
Reset and defaults
- Reset is synchronous, active-low on rst_n, clocked by pixel_clk.
- While rst_n=0: all outputs 0, sync flops 0, stable levels 0, all counters 0, centre FSM in IDLE.
- A button held through reset is treated as a fresh press once debounced after reset.
- Reset asserted mid-press or mid-count aborts everything; no pulse is emitted for that press.

Synchronise and debounce (per button)
- Two-flop synchroniser, output s.
- Counter cnt: cleared whenever s==stable; otherwise increments.
- When s!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=s and cnt<=0.
- Any glitch shorter than DEBOUNCE_CYCLES cycles leaves stable unchanged.
- Latency from the first edge that samples raw=1 to stable=1 is DEBOUNCE_CYCLES+2 edges. Pulses are registered, so a press pulse is high in the cycle after stable rises.

Centre FSM (states IDLE, PRESSED, LONG_FIRED; hold counter hc)
- IDLE: on stable rise, go to PRESSED with hc=0.
- PRESSED: hc increments each cycle.
  - If stable falls: pulse button_c_short, go to IDLE.
  - Else if hc reaches LONG_PRESS_CYCLES-1: pulse button_c_long, go to LONG_FIRED.
- LONG_FIRED: wait for stable fall, then go to IDLE with no pulse.
- Exactly one of short/long fires per press; never both, never twice.

Direction buttons (each independent; own repeat counter rc, width ceil(log2(max(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES))))
- Stable rise: pulse once, load rc=0, arm the delay phase.
- While held in the delay phase: when rc reaches REPEAT_DELAY_CYCLES-1, pulse, rc=0, switch to the period phase.
- In the period phase: pulse every REPEAT_PERIOD_CYCLES.
- Stable fall: clear rc and phase immediately; no further pulses.
- Simultaneous directions are all reported; pulses may coincide in one cycle. Resolving priority is game_fsm's job.
- Counters saturate-free by construction: they are always cleared on reaching their terminal value.

Decomposition:
- Shared package btn_pkg:
  - button index localparams BTN_C=0, BTN_U=1, BTN_D=2, BTN_L=3, BTN_R=4, NUM_BTN=5;
  - centre FSM typedef enum {IDLE, PRESSED, LONG_FIRED}.
- One sub-module, btn_debounce: synchroniser plus debounce counter, outputs stable level and registered rise/fall strobes; instantiated NUM_BTN times.
- Repeat and centre logic stay in button_conditioner.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=5.
- Bounce rejection: btn_raw[1] toggles 1,0,1,0 every 2 cycles, then settles 1 -> exactly one button_u pulse, 7 cycles after settle (DEBOUNCE_CYCLES+3); btn_level[1]=1.
- Short press: centre held 12 cycles clean -> one button_c_short pulse after the debounced release; button_c_long never asserts.
- Long press: centre held 40 cycles -> button_c_long pulses exactly once, 20 cycles after stable rise; no button_c_short on release.
- Auto-repeat: btn_raw[4] held 40 cycles after debounce -> button_r pulses at offsets 0, 10, 15, 20, 25, 30, 35 relative to the first pulse; none after stable falls.
- Simultaneous: btn_raw[2] and btn_raw[3] rise in the same cycle -> button_d and button_l pulse in the same cycle; repeats stay aligned.
- Reset mid-press: centre held, rst_n=0 for 1 cycle at hc=15 -> no short or long pulse; all outputs 0 during reset; still-held button re-debounced and treated as a new press (long fires 20 cycles after the new stable rise).
